// File: rtl/spi_inert_resp_if.sv
// SPI bus between the inert_intf master and the sensor responder.
interface spi_inert_resp_if;
  logic SS_n;
  logic SCLK;
  logic MOSI;
  logic MISO;

  modport master (output SS_n, output SCLK, output MOSI, input MISO);
  modport slave  (input SS_n, input SCLK, input MOSI, output MISO);
endinterface

// File: rtl/spi_inert_resp.sv
// Inertial sensor SPI responder: 16-bit frames, register file, periodic sampling, INT.
// Optional STATUS register with sticky overrun is built when STATUS_OVR_EN is defined.
module spi_inert_resp #(
  parameter int         SAMPLE_CYCLES = 2048,
  parameter logic [7:0] WHO_AM_I_VAL  = 8'h6A
) (
  input  logic              clk,
  input  logic              rst,
  spi_inert_resp_if.slave   spi,
  output logic              INT,
  input  logic [15:0]       ptch_in,
  input  logic [15:0]       roll_in,
  input  logic [15:0]       yaw_in
);

  localparam int CNT_W = $clog2(SAMPLE_CYCLES);

  typedef enum logic [1:0] {IDLE, CMD, DATA, DONE} state_t;

  // Input synchronisers (p0/p1 metastability, p2 edge history)
  logic r_ss_p0, r_ss_p1, r_ss_p2;
  logic r_sclk_p0, r_sclk_p1, r_sclk_p2;
  logic r_mosi_p0, r_mosi_p1;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_ss_p0   <= 1'b1;
      r_ss_p1   <= 1'b1;
      r_ss_p2   <= 1'b1;
      r_sclk_p0 <= 1'b1;
      r_sclk_p1 <= 1'b1;
      r_sclk_p2 <= 1'b1;
      r_mosi_p0 <= 1'b0;
      r_mosi_p1 <= 1'b0;
    end else begin
      r_ss_p0   <= spi.SS_n;
      r_ss_p1   <= r_ss_p0;
      r_ss_p2   <= r_ss_p1;
      r_sclk_p0 <= spi.SCLK;
      r_sclk_p1 <= r_sclk_p0;
      r_sclk_p2 <= r_sclk_p1;
      r_mosi_p0 <= spi.MOSI;
      r_mosi_p1 <= r_mosi_p0;
    end
  end

  logic w_ss_fall, w_ss_rise, w_sclk_rise, w_sclk_fall;
  assign w_ss_fall   = ~r_ss_p1 &  r_ss_p2;
  assign w_ss_rise   =  r_ss_p1 & ~r_ss_p2;
  assign w_sclk_rise =  r_sclk_p1 & ~r_sclk_p2;
  assign w_sclk_fall = ~r_sclk_p1 &  r_sclk_p2;

  state_t      r_state;
  logic [3:0]  r_bit_cnt;
  logic [6:0]  r_cmd;
  logic [7:0]  r_shreg;
  logic        r_miso;
  logic [6:0]  r_addr;
  logic        r_rw;

  // Register file
  logic [7:0]       r_int1_ctrl, r_ctrl1_xl, r_ctrl2_g;
  logic [15:0]      r_ptch, r_roll, r_yaw;
  logic             r_data_rdy;
  logic [CNT_W-1:0] r_smp_cnt;
`ifdef STATUS_OVR_EN
  logic             r_ovr;
`endif

  // Address is complete on the 8th rise: earlier bits in r_cmd, last bit on MOSI now
  logic [6:0] w_addr_cmd;
  logic [7:0] w_rd_data;
  assign w_addr_cmd = {r_cmd[5:0], r_mosi_p1};

  always_comb begin
    w_rd_data = 8'h00;
    case (w_addr_cmd)
      7'h0F: w_rd_data = WHO_AM_I_VAL;
      7'h0D: w_rd_data = r_int1_ctrl;
      7'h10: w_rd_data = r_ctrl1_xl;
      7'h11: w_rd_data = r_ctrl2_g;
`ifdef STATUS_OVR_EN
      7'h1E: w_rd_data = {6'b0, r_ovr, r_data_rdy};
`endif
      7'h22: w_rd_data = r_ptch[7:0];
      7'h23: w_rd_data = r_ptch[15:8];
      7'h24: w_rd_data = r_roll[7:0];
      7'h25: w_rd_data = r_roll[15:8];
      7'h26: w_rd_data = r_yaw[7:0];
      7'h27: w_rd_data = r_yaw[15:8];
      default: w_rd_data = 8'h00;
    endcase
  end

  // Frame completes on the 16th rise unless SS_n rises in the same cycle
  logic       w_commit, w_wr, w_rd_done;
  logic [7:0] w_wdata;
  assign w_commit  = (r_state == DATA) & w_sclk_rise & (r_bit_cnt == 4'd15) & ~w_ss_rise;
  assign w_wr      = w_commit & ~r_rw;
  assign w_rd_done = w_commit &  r_rw;
  assign w_wdata   = {r_cmd[6:0], r_mosi_p1};

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= IDLE;
      r_bit_cnt <= 4'd0;
      r_cmd     <= 7'd0;
      r_shreg   <= 8'd0;
      r_miso    <= 1'b0;
      r_addr    <= 7'd0;
      r_rw      <= 1'b0;
    end else if (r_state != IDLE && w_ss_rise) begin
      r_state <= IDLE;
      r_miso  <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          r_miso <= 1'b0;
          if (w_ss_fall) begin
            r_state   <= CMD;
            r_bit_cnt <= 4'd0;
            r_cmd     <= 7'd0;
          end
        end
        CMD: begin
          r_miso <= 1'b0;
          if (w_sclk_rise) begin
            r_cmd     <= {r_cmd[5:0], r_mosi_p1};
            r_bit_cnt <= r_bit_cnt + 4'd1;
            if (r_bit_cnt == 4'd7) begin
              r_shreg <= w_rd_data;
              r_addr  <= w_addr_cmd;
              r_rw    <= r_cmd[6];
              r_state <= DATA;
            end
          end
        end
        DATA: begin
          if (w_sclk_fall) begin
            r_miso  <= r_shreg[7];
            r_shreg <= {r_shreg[6:0], 1'b0};
          end
          if (w_sclk_rise) begin
            r_cmd     <= {r_cmd[5:0], r_mosi_p1};
            r_bit_cnt <= r_bit_cnt + 4'd1;
            if (r_bit_cnt == 4'd15) r_state <= DONE;
          end
        end
        DONE: r_state <= DONE;
        default: r_state <= IDLE;
      endcase
    end
  end

  assign spi.MISO = r_miso;

  logic w_wrap;
  assign w_wrap = (r_smp_cnt == CNT_W'(SAMPLE_CYCLES - 1));

  always_ff @(posedge clk) begin
    if (rst) begin
      r_int1_ctrl <= 8'd0;
      r_ctrl1_xl  <= 8'd0;
      r_ctrl2_g   <= 8'd0;
      r_ptch      <= 16'd0;
      r_roll      <= 16'd0;
      r_yaw       <= 16'd0;
      r_data_rdy  <= 1'b0;
      r_smp_cnt   <= '0;
    end else begin
      if (w_wr) begin
        case (r_addr)
          7'h0D: r_int1_ctrl <= w_wdata;
          7'h10: r_ctrl1_xl  <= w_wdata;
          7'h11: r_ctrl2_g   <= w_wdata;
          default: ;
        endcase
      end
      r_smp_cnt <= w_wrap ? '0 : r_smp_cnt + 1'b1;
      if (w_wrap) begin
        r_ptch <= ptch_in;
        r_roll <= roll_in;
        r_yaw  <= yaw_in;
      end
      // New sample wins over a simultaneous yaw-high read completion
      if (w_wrap)
        r_data_rdy <= 1'b1;
      else if (w_rd_done && r_addr == 7'h27)
        r_data_rdy <= 1'b0;
    end
  end

`ifdef STATUS_OVR_EN
  always_ff @(posedge clk) begin
    if (rst)
      r_ovr <= 1'b0;
    else if (w_wrap && r_data_rdy)
      r_ovr <= 1'b1;
    else if (w_rd_done && r_addr == 7'h1E)
      r_ovr <= 1'b0;
  end
`endif

  assign INT = r_data_rdy & r_int1_ctrl[1];

endmodule
